// File: rtl/phy_rx_deser.sv
// phy_rx_deser: receive-side deserializer of the phy link.
// Shifts the clk_8f serial stream into a byte window, aligns on the COMMA
// idle symbol, declares the link active after SYNC_COUNT consecutive aligned
// commas, then delivers one byte every 8 bit clocks.
// Ports:
//   clk_8f      bit clock, one serial bit per rising edge
//   reset_L     asynchronous active-low reset
//   enable      receiver enable; low forces SEARCH and clears the outputs
//   data_in     serial data, MSB first
//   data_out    recovered byte
//   valid_out   data_out holds a non-comma byte
//   byte_strobe one-cycle pulse each time data_out/valid_out update
//   active      link synchronized
module phy_rx_deser #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned SYNC_COUNT = 4
) (
  input  logic       clk_8f,
  input  logic       reset_L,
  input  logic       enable,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned BC_W   = 4;

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  localparam logic [BC_W-1:0] BC_LAST = BC_W'(SYNC_COUNT - 1);

  logic [1:0]        state, state_nxt;
  logic [BYTE_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [BC_W-1:0]   bc_cnt, bc_cnt_nxt;
  logic [BYTE_W-1:0] data_nxt;
  logic              valid_nxt;
  logic              strobe_nxt;
  logic              active_nxt;
  logic              is_comma_c;
  logic              boundary_c;

  assign is_comma_c = (shreg == COMMA);
  assign boundary_c = (bit_cnt == '0);

  // Serial shift window; keeps running while disabled so realignment can start at once.
  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      shreg <= '0;
    end else begin
      shreg <= {shreg[BYTE_W-2:0], data_in};
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      state       <= ST_SEARCH;
      bit_cnt     <= '0;
      bc_cnt      <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
      active      <= 1'b0;
    end else begin
      state       <= state_nxt;
      bit_cnt     <= bit_cnt_nxt;
      bc_cnt      <= bc_cnt_nxt;
      data_out    <= data_nxt;
      valid_out   <= valid_nxt;
      byte_strobe <= strobe_nxt;
      active      <= active_nxt;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    bc_cnt_nxt  = bc_cnt;
    data_nxt    = data_out;
    valid_nxt   = valid_out;
    strobe_nxt  = 1'b0;

    if (!enable) begin
      state_nxt   = ST_SEARCH;
      bit_cnt_nxt = '0;
      bc_cnt_nxt  = '0;
      data_nxt    = '0;
      valid_nxt   = 1'b0;
    end else begin
      case (state)
        ST_SEARCH: begin
          // A comma seen here fixes the byte phase: the next byte ends 8 edges later.
          if (is_comma_c) begin
            state_nxt   = ST_SYNC;
            bit_cnt_nxt = CNT_W'(1);
            bc_cnt_nxt  = BC_W'(1);
          end
        end
        ST_SYNC: begin
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
          if (boundary_c) begin
            if (is_comma_c) begin
              if (bc_cnt == BC_LAST) begin
                state_nxt  = ST_ACTIVE;
                bc_cnt_nxt = '0;
                strobe_nxt = 1'b1;
                data_nxt   = COMMA;
                valid_nxt  = 1'b0;
              end else begin
                bc_cnt_nxt = bc_cnt + BC_W'(1);
              end
            end else begin
              // Non-comma on an aligned boundary rejects the alignment.
              state_nxt   = ST_SEARCH;
              bc_cnt_nxt  = '0;
              bit_cnt_nxt = '0;
            end
          end
        end
        ST_ACTIVE: begin
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
          if (boundary_c) begin
            strobe_nxt = 1'b1;
            data_nxt   = shreg;
            valid_nxt  = !is_comma_c;
          end
        end
        default: begin
          state_nxt   = ST_SEARCH;
          bit_cnt_nxt = '0;
          bc_cnt_nxt  = '0;
        end
      endcase
    end

    active_nxt = (state_nxt == ST_ACTIVE);
  end

endmodule
